mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Port clk, input, 1 bit: system clock.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port req, input, 4 bits: per-requester request, bit i = requester i.
REQ-005 Port data_in, input, 4 bits: per-requester 1-bit data; bit i is owned by requester i.
REQ-006 Port out_ready, input, 1 bit: downstream accepts y this cycle.
REQ-007 Port lock, input, 4 bits: per-requester hold-grant request; present only under MUX4_ARB_LOCK_EN.
REQ-008 Port grant, output, 4 bits: one-hot grant, all zero when idle.
REQ-009 Port sel, output, 2 bits: binary index of the granted requester; drives the shared mux select.
REQ-010 Port out_valid, output, 1 bit: y holds a valid beat.
REQ-011 Port y, output, 1 bit: data_in[sel], combinational through the shared mux.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and GRANT; out_valid SHALL equal (state == GRANT), and grant SHALL equal the one-hot decode of sel in GRANT and 4'b0000 in IDLE.
REQ-013 In IDLE, if req != 0 at an edge, the block SHALL pick the first set req bit scanning cyclically from ptr (ptr, ptr+1, ... mod 4), register it into sel, and enter GRANT; out_valid SHALL be high in the cycle after req is sampled (1-cycle latency).
REQ-014 In GRANT, a transfer SHALL occur on an edge where out_valid && out_ready; without a transfer, sel, grant and state SHALL hold regardless of req changes, including withdrawal of req[sel].
REQ-015 On a transfer, ptr SHALL become (sel + 1) mod 4, with 2-bit wrap so that 3 goes to 0.
REQ-016 On a transfer, if req != 0, the block SHALL re-arbitrate in the same edge using the new ptr and remain in GRANT, giving back-to-back beats at 1 beat/cycle; otherwise it SHALL return to IDLE.
REQ-017 A requester whose req is still set after its transfer SHALL be served last among concurrent requesters (round-robin fairness); a sole requester SHALL be re-granted on consecutive cycles.
REQ-018 y SHALL track data_in[sel] combinationally; the requester SHALL hold data_in[sel] stable while out_valid && !out_ready.

Reset
REQ-019 While rst is high at an edge: state = IDLE, ptr = 0, sel = 2'b00, grant = 4'b0000, out_valid = 0.
REQ-020 Reset asserted mid-GRANT SHALL drop the pending beat without a transfer; the first grant after reset SHALL follow ptr = 0.

Configuration
REQ-021 Macro MUX4_ARB_LOCK_EN SHALL compile the lock port and lock feature in or out.
REQ-022 With MUX4_ARB_LOCK_EN defined, on a transfer with lock[sel] = 1 and req[sel] = 1, the block SHALL keep sel, keep ptr unchanged, and stay in GRANT; lock on a non-granted requester SHALL be ignored.
REQ-023 Without MUX4_ARB_LOCK_EN, there SHALL be no lock port, and behaviour SHALL be exactly REQ-012 to REQ-018.

Structure
REQ-024 Package mux4_arb_pkg SHALL hold NUM_REQ = 4, SEL_W = 2, and typedef enum logic {IDLE, GRANT} arb_state_t.
REQ-025 The data path SHALL instantiate the team's existing mux4to1 sub-module (sel, data_in -> y); arbitration logic SHALL stay in mux4_rr_arbiter.

Verification
REQ-026 Reset, then req = 4'b0100, out_ready = 1 -> next cycle sel = 2'b10, grant = 4'b0100, out_valid = 1, y = data_in[2]; after the transfer with req = 0 -> IDLE, grant = 0.
REQ-027 req = 4'b1111 held, out_ready = 1 -> grants in order 0, 1, 2, 3, 0 on consecutive cycles, with out_valid high continuously.
REQ-028 Granted requester 1, out_ready = 0 for 5 cycles while req changes to 4'b1000 -> sel stays 2'b01 and out_valid stays 1; the transfer occurs when out_ready rises, then requester 3 is granted.
REQ-029 ptr = 3 with req = 4'b1001 -> requester 3 is granted first, then requester 0 (wrap-around).
REQ-030 rst asserted during GRANT with out_ready = 0 -> next cycle out_valid = 0, grant = 0, and the next grant follows ptr = 0.
REQ-031 With MUX4_ARB_LOCK_EN: req = 4'b0011, lock = 4'b0001, out_ready = 1 -> requester 0 gets 3 consecutive beats; after lock[0] drops, requester 1 is granted.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared constants, state type and the round-robin pick helper for mux4_rr_arbiter.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // First set request bit scanning cyclically upward from start; returns start if none set.
    function automatic logic [SEL_W-1:0] rrPick(input logic [NUM_REQ-1:0] reqVec,
                                                input logic [SEL_W-1:0]   start);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] pick;
        logic             found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = start + SEL_W'(i);
            if (!found && reqVec[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4to1.sv
// Shared 4:1 one-bit data mux driven by the arbiter select.
module mux4to1
    import mux4_arb_pkg::*;
(
    input  logic [SEL_W-1:0]   sel_i,
    input  logic [NUM_REQ-1:0] data_i,
    output logic               y_o
);

    assign y_o = data_i[sel_i];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter steering one requester's data bit onto y.
// Define MUX4_ARB_LOCK_EN to add the lock port that holds a grant across beats.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] data_in,
    input  logic               out_ready,
`ifdef MUX4_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] lock,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    output logic               y
);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             holdGrant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef MUX4_ARB_LOCK_EN
    assign holdGrant = lock[sel_q] && req[sel_q];
`else
    assign holdGrant = 1'b0;
`endif

    // A grant only moves on a transfer; re-arbitration starts just past the served requester.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    sel_d   = rrPick(req, ptr_q);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (out_ready && !holdGrant) begin
                    ptr_d = sel_q + 2'd1;
                    if (req != '0) begin
                        sel_d = rrPick(req, sel_q + 2'd1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (state_q == GRANT);
    assign sel       = sel_q;
    assign grant     = out_valid ? (NUM_REQ'(1) << sel_q) : '0;

    mux4to1 u_mux (
        .sel_i  (sel_q),
        .data_i (data_in),
        .y_o    (y)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter; covers the lock path when MUX4_ARB_LOCK_EN is defined.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] data_in;
    logic       out_ready;
`ifdef MUX4_ARB_LOCK_EN
    logic [3:0] lock;
`endif
    logic [3:0] grant;
    logic [1:0] sel;
    logic       out_valid;
    logic       y;

    int checks;
    int errors;

    mux4_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
`ifdef MUX4_ARB_LOCK_EN
        .lock      (lock),
`endif
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, then advance one rising edge and settle before sampling.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic rdy);
        rst       = r;
        req       = rq;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req       = '0;
        data_in   = '0;
        out_ready = 1'b0;
`ifdef MUX4_ARB_LOCK_EN
        lock      = '0;
`endif
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_sel", 32'(sel), 32'h0);

        $display("[TB] single requester");
        data_in = 4'b0100;
        applyStimulus(1'b0, 4'b0100, 1'b1);
        checkOutput("single_sel", 32'(sel), 32'h2);
        checkOutput("single_grant", 32'(grant), 32'h4);
        checkOutput("single_valid", 32'(out_valid), 32'h1);
        checkOutput("single_y", 32'(y), 32'h1);
        data_in = 4'b1011;
        #1;
        checkOutput("single_y_track", 32'(y), 32'h0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("single_idle_grant", 32'(grant), 32'h0);
        checkOutput("single_idle_valid", 32'(out_valid), 32'h0);

        $display("[TB] wrap from ptr 3");
        applyStimulus(1'b0, 4'b1001, 1'b1);
        checkOutput("wrap_first", 32'(sel), 32'h3);
        applyStimulus(1'b0, 4'b1001, 1'b1);
        checkOutput("wrap_second", 32'(sel), 32'h0);
        checkOutput("wrap_valid", 32'(out_valid), 32'h1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("wrap_idle", 32'(out_valid), 32'h0);

        $display("[TB] full rotation");
        applyStimulus(1'b1, 4'b0000, 1'b0);
        data_in = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b1111, 1'b1);
            checkOutput($sformatf("rot_sel%0d", i), 32'(sel), 32'(i % 4));
            checkOutput($sformatf("rot_valid%0d", i), 32'(out_valid), 32'h1);
            checkOutput($sformatf("rot_y%0d", i), 32'(y), 32'(i % 2));
        end
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("rot_idle", 32'(out_valid), 32'h0);

        $display("[TB] stall holds grant");
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("stall_first", 32'(sel), 32'h1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b1000, 1'b0);
            checkOutput($sformatf("stall_sel%0d", i), 32'(sel), 32'h1);
            checkOutput($sformatf("stall_valid%0d", i), 32'(out_valid), 32'h1);
        end
        applyStimulus(1'b0, 4'b1000, 1'b1);
        checkOutput("stall_next", 32'(sel), 32'h3);
        checkOutput("stall_next_grant", 32'(grant), 32'h8);
        applyStimulus(1'b0, 4'b0000, 1'b1);

        $display("[TB] reset during grant");
        applyStimulus(1'b0, 4'b0100, 1'b1);
        checkOutput("regrant_first", 32'(sel), 32'h2);
        applyStimulus(1'b0, 4'b0100, 1'b1);
        checkOutput("regrant_again", 32'(sel), 32'h2);
        checkOutput("regrant_valid", 32'(out_valid), 32'h1);
        applyStimulus(1'b1, 4'b0100, 1'b0);
        checkOutput("midrst_valid", 32'(out_valid), 32'h0);
        checkOutput("midrst_grant", 32'(grant), 32'h0);
        applyStimulus(1'b0, 4'b1010, 1'b1);
        checkOutput("postrst_sel", 32'(sel), 32'h1);
        applyStimulus(1'b0, 4'b0000, 1'b1);

`ifdef MUX4_ARB_LOCK_EN
        $display("[TB] lock holds grant");
        applyStimulus(1'b1, 4'b0000, 1'b0);
        lock = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0011, 1'b1);
            checkOutput($sformatf("lock_beat%0d", i), 32'(sel), 32'h0);
            checkOutput($sformatf("lock_valid%0d", i), 32'(out_valid), 32'h1);
        end
        lock = 4'b0000;
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("lock_release", 32'(sel), 32'h1);
        lock = 4'b0100;
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("lock_ignored", 32'(sel), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
